// File: rtl/sync_word_memory_if.sv
// Access bus for sync_word_memory: word address, chip select, write enable,
// write data and registered read data.
interface sync_word_memory_if;
    logic [31:0] addr_i;
    logic        cs;
    logic        we;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output addr_i,
        output cs,
        output we,
        output data_i,
        input  data_o
    );

    modport slave (
        input  addr_i,
        input  cs,
        input  we,
        input  data_i,
        output data_o
    );
endinterface

// File: rtl/sync_word_memory.sv
// Single-port word-addressed RAM with one registered access per clock edge,
// write-first read data and an asynchronous reset that clears the whole array.
module sync_word_memory #(
    parameter int unsigned size = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sync_word_memory_if.slave    bus
);

    localparam int unsigned AW     = (size > 1) ? $clog2(size) : 1;
    localparam logic [31:0] SIZE_W = 32'(size);

    logic [31:0]   memory [0:size-1];
    logic [31:0]   data_q;
    logic [31:0]   data_d;
    logic          wr_en;
    logic          rd_en;
    logic          in_range;
    logic [AW-1:0] idx;

    // An unknown cs or we makes both enables false, so nothing happens.
    always_comb begin
        wr_en    = bus.cs && bus.we;
        rd_en    = bus.cs && !bus.we;
        in_range = (bus.addr_i < SIZE_W);
        idx      = bus.addr_i[AW-1:0];
    end

    // Out-of-range writes are dropped entirely and leave data_o untouched.
    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            if (in_range) begin
                data_d = bus.data_i;
            end
        end else if (rd_en) begin
            data_d = in_range ? memory[idx] : 32'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= 32'd0;
            for (int i = 0; i < int'(size); i++) begin
                memory[i] <= 32'd0;
            end
        end else begin
            data_q <= data_d;
            if (wr_en && in_range) begin
                memory[idx] <= bus.data_i;
            end
        end
    end

    assign bus.data_o = data_q;

endmodule

// File: tb/tb_sync_word_memory.sv
// Directed bench for sync_word_memory: reset, gated access, write-first,
// out-of-range handling and asynchronous reset behaviour.
module tb_sync_word_memory;

    logic clk_i;
    logic rst_i;
    int   compared;
    int   mismatched;

    sync_word_memory_if bus ();

    sync_word_memory #(.size(32)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic access(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.cs     = c;
        bus.we     = w;
        bus.addr_i = a;
        bus.data_i = d;
        tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_i      = 1'b1;
        bus.cs     = 1'b0;
        bus.we     = 1'b0;
        bus.addr_i = 32'd0;
        bus.data_i = 32'd0;
        tick();
        tick();
        check("reset_data", bus.data_o, 32'd0);
        check("reset_mem31", dut.memory[31], 32'd0);
        rst_i = 1'b0;

        // Idle with we undefined: nothing changes.
        access(1'b0, 1'bx, 32'd1, 32'd42);
        check("idle_data", bus.data_o, 32'd0);
        check("idle_mem1", dut.memory[1], 32'd0);

        access(1'b1, 1'b0, 32'd1, 32'd42);
        check("read1_zero", bus.data_o, 32'd0);

        access(1'b0, 1'b1, 32'd1, 32'd42);
        check("nocs_mem1", dut.memory[1], 32'd0);
        check("nocs_data", bus.data_o, 32'd0);

        access(1'b1, 1'b1, 32'd1, 32'd42);
        check("wr1_mem1", dut.memory[1], 32'd42);
        check("wr1_wfirst", bus.data_o, 32'd42);

        access(1'b1, 1'b1, 32'd31, 32'hDEADBEEF);
        check("wr31_wfirst", bus.data_o, 32'hDEADBEEF);
        access(1'b1, 1'b1, 32'd0, 32'h12345678);
        check("wr0_wfirst", bus.data_o, 32'h12345678);
        access(1'b1, 1'b0, 32'd31, 32'd0);
        check("rd31", bus.data_o, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd0, 32'd0);
        check("rd0", bus.data_o, 32'h12345678);

        // Idle hold: data_o keeps the last read value.
        access(1'b0, 1'b0, 32'd31, 32'd0);
        check("idle_hold", bus.data_o, 32'h12345678);

        access(1'b1, 1'b1, 32'd32, 32'hFFFFFFFF);
        check("oor_wr_mem0", dut.memory[0], 32'h12345678);
        access(1'b1, 1'b0, 32'd32, 32'd0);
        check("oor_rd32", bus.data_o, 32'd0);
        access(1'b1, 1'b0, 32'd1, 32'd0);
        check("rd1", bus.data_o, 32'd42);
        access(1'b1, 1'b0, 32'h8000_0001, 32'd0);
        check("oor_rd_high", bus.data_o, 32'd0);
        access(1'b1, 1'b0, 32'd1, 32'd0);
        check("rd1_again", bus.data_o, 32'd42);

        // Reset mid-cycle with a write pending on the next edge.
        bus.cs     = 1'b1;
        bus.we     = 1'b1;
        bus.addr_i = 32'd5;
        bus.data_i = 32'h55;
        #3;
        rst_i = 1'b1;
        #1;
        check("async_rst_data", bus.data_o, 32'd0);
        check("async_rst_mem1", dut.memory[1], 32'd0);
        tick();
        check("rst_edge_mem5", dut.memory[5], 32'd0);
        check("rst_edge_data", bus.data_o, 32'd0);
        rst_i = 1'b0;

        for (int a = 0; a < 32; a++) begin
            access(1'b1, 1'b0, a, 32'd0);
            check($sformatf("post_rst_rd%0d", a), bus.data_o, 32'd0);
        end

        access(1'b0, 1'b0, 32'd0, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sync_word_memory.md
Name: sync_word_memory

Overview:
- Single-port, word-addressed synchronous RAM of `size` 32-bit words.
- Used as instruction/data storage in the MIPS datapath.
- One registered read/write access per rising clock edge, gated by chip-select `cs` and write-enable `we`.
- Storage array is named `memory` and is indexed 0..size-1, so benches can preload or inspect words hierarchically.

Parameters:
- size, 32, number of 32-bit words in the array; legal range 1..65536.

Ports:
- clk_i  input  1  system clock; all accesses are sampled on its rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- addr_i  input  32  word index; not a byte address.
- cs  input  1  chip select; no access takes place when low.
- we  input  1  write enable; only meaningful when cs=1.
- data_i  input  32  write data.
- data_o  output  32  registered read data.

Behaviour:
- Reset:
  - rst_i=1 immediately forces data_o=0 and clears every memory word to 0, regardless of clock.
  - The array and data_o stay at 0 while rst_i is high.
  - Deassertion is synchronised by the integrator; the first access is honoured on the first rising edge with rst_i=0.
- Read (cs=1, we=0):
  - At the rising edge, data_o <= memory[addr_i].
  - Latency is 1 cycle; data_o is valid after the edge and stable until the next qualifying edge.
- Write (cs=1, we=1):
  - At the rising edge, memory[addr_i] <= data_i.
  - Write-first: data_o <= data_i in the same edge.
- Idle (cs=0):
  - No array change; data_o holds its previous value. This applies regardless of we.
  - Before any access after power-up without reset, data_o is X/undefined; after reset it is 0.
- Out of range (addr_i >= size):
  - Reads return data_o=0.
  - Writes are ignored; no aliasing or wrap-around.
  - Compare against the full 32-bit addr_i.
- X on control inputs:
  - cs or we unknown is treated as no access.
  - Simulation-only $display warnings are optional.
- Reset during an edge: reset wins; a coincident write is discarded.
- No combinational path from any input to data_o.

Test Plan:
1. Array preloaded to 0; addr_i=1, cs=0 (we undefined), one clock -> no access, array unchanged, data_o keeps its previous value (X if never accessed and never reset).
2. addr_i=1, cs=1, we=0, one clock -> data_o=0 after the edge.
3. data_i=42, cs=1, we=0, clock; then cs=0, we=1, clock -> memory[1] stays 0 and data_o stays 0 (no write without cs&we); then cs=1, we=1, clock -> memory[1]=42 and data_o=42 (write-first).
4. Write 0xDEADBEEF to addr 31 and 0x12345678 to addr 0, then read both -> data_o=0xDEADBEEF and 0x12345678 respectively, one cycle after each read edge. addr 32 write 0xFFFFFFFF -> ignored, memory[0] unchanged; addr 32 read -> data_o=0.
5. With nonzero contents and data_o=42, assert rst_i mid-cycle (between edges) -> data_o=0 immediately; every word reads 0 after release; a write coincident with reset is lost.
